// File: rtl/pe_param.sv
// Parameterised systolic PE with OS/WS dataflows, double-buffered accumulators and round-half-even drain.
// Define PE_SATURATE_EN to saturate out_c/out_b to OUT_W; otherwise they wrap to the low OUT_W bits.
module pe_param #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned OUT_W    = 20,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned SHIFT_W  = 5,
  parameter int unsigned ID_W     = 3,
  parameter int unsigned DATAFLOW = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IN_W-1:0]    in_a_i,
  input  logic [OUT_W-1:0]   in_b_i,
  input  logic [OUT_W-1:0]   in_d_i,
  input  logic               in_control_dataflow_i,
  input  logic               in_control_propagate_i,
  input  logic [SHIFT_W-1:0] in_control_shift_i,
  input  logic [ID_W-1:0]    in_id_i,
  input  logic               in_last_i,
  input  logic               in_valid_i,
  output logic [IN_W-1:0]    out_a_o,
  output logic [OUT_W-1:0]   out_b_o,
  output logic [OUT_W-1:0]   out_c_o,
  output logic               out_control_dataflow_o,
  output logic               out_control_propagate_o,
  output logic [SHIFT_W-1:0] out_control_shift_o,
  output logic [ID_W-1:0]    out_id_o,
  output logic               out_last_o,
  output logic               out_valid_o,
  output logic               bad_dataflow_o
);

  localparam logic [ACC_W-1:0] One = ACC_W'(1);
`ifdef PE_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  // Arithmetic right shift with round-half-to-even; large shifts clamp to ACC_W-1.
  function automatic logic signed [ACC_W-1:0] rshift(input logic signed [ACC_W-1:0] x,
                                                     input logic [SHIFT_W-1:0] s);
    int unsigned sc;
    logic        rb, odd, sticky;
    logic signed [ACC_W-1:0] res;
    sc = 32'(s);
    if (sc > ACC_W - 1) sc = ACC_W - 1;
    if (sc == 0) begin
      res = x;
    end else begin
      rb     = |(x & (One << (sc - 1)));
      odd    = |(x & (One << sc));
      sticky = |(x & ((One << (sc - 1)) - One));
      res    = (x >>> sc) + {{(ACC_W-1){1'b0}}, rb & (sticky | odd)};
    end
    return res;
  endfunction

  function automatic logic [OUT_W-1:0] clip(input logic signed [ACC_W-1:0] x);
    logic [OUT_W-1:0] res;
`ifdef PE_SATURATE_EN
    if (x > SatMax)      res = SatMax[OUT_W-1:0];
    else if (x < SatMin) res = SatMin[OUT_W-1:0];
    else                 res = x[OUT_W-1:0];
`else
    res = x[OUT_W-1:0];
`endif
    return res;
  endfunction

  logic signed [ACC_W-1:0] c1_q, c1_d, c2_q, c2_d;
  logic                    last_q, last_d;
  logic [IN_W-1:0]         out_a_q, out_a_d;
  logic [OUT_W-1:0]        out_b_q, out_b_d, out_c_q, out_c_d;
  logic                    out_df_q, out_df_d, out_prop_q, out_prop_d;
  logic [SHIFT_W-1:0]      out_sh_q, out_sh_d;
  logic [ID_W-1:0]         out_id_q, out_id_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, bad_q;

  logic                    mode_ok, ok, flip;
  logic [SHIFT_W-1:0]      sh;
  logic signed [ACC_W-1:0] a_x, b_x, d_x, w_x, drain, other, acc, ws_sum;

  assign mode_ok = (DATAFLOW == 2) ||
                   ((DATAFLOW == 0) && !in_control_dataflow_i) ||
                   ((DATAFLOW == 1) && in_control_dataflow_i);
  assign ok      = in_valid_i && mode_ok;
  assign flip    = (last_q != in_control_propagate_i);
  assign sh      = flip ? in_control_shift_i : '0;

  assign a_x    = {{(ACC_W-IN_W){in_a_i[IN_W-1]}}, in_a_i};
  assign b_x    = {{(ACC_W-OUT_W){in_b_i[OUT_W-1]}}, in_b_i};
  assign d_x    = {{(ACC_W-OUT_W){in_d_i[OUT_W-1]}}, in_d_i};
  // propagate selects which bank drains; the other accumulates (OS) or supplies the weight (WS)
  assign drain  = in_control_propagate_i ? c1_q : c2_q;
  assign other  = in_control_propagate_i ? c2_q : c1_q;
  assign w_x    = {{(ACC_W-IN_W){other[IN_W-1]}}, other[IN_W-1:0]};
  assign acc    = other + a_x * b_x;
  assign ws_sum = b_x + a_x * w_x;

  always_comb begin
    c1_d       = c1_q;
    c2_d       = c2_q;
    last_d     = last_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    out_c_d    = out_c_q;
    out_df_d   = out_df_q;
    out_prop_d = out_prop_q;
    out_sh_d   = out_sh_q;
    out_id_d   = out_id_q;
    out_last_d = out_last_q;
    if (ok) begin
      last_d     = in_control_propagate_i;
      out_a_d    = in_a_i;
      out_df_d   = in_control_dataflow_i;
      out_prop_d = in_control_propagate_i;
      out_sh_d   = in_control_shift_i;
      out_id_d   = in_id_i;
      out_last_d = in_last_i;
      if (!in_control_dataflow_i) begin
        out_c_d = clip(rshift(drain, sh));
        out_b_d = in_b_i;
        if (in_control_propagate_i) begin
          c2_d = acc;
          c1_d = d_x;
        end else begin
          c1_d = acc;
          c2_d = d_x;
        end
      end else begin
        out_c_d = clip(drain);
        out_b_d = clip(ws_sum);
        if (in_control_propagate_i) c1_d = d_x;
        else                        c2_d = d_x;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c1_q        <= '0;
      c2_q        <= '0;
      last_q      <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      out_df_q    <= 1'b0;
      out_prop_q  <= 1'b0;
      out_sh_q    <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      last_q      <= last_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      out_df_q    <= out_df_d;
      out_prop_q  <= out_prop_d;
      out_sh_q    <= out_sh_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      out_valid_q <= ok;
      bad_q       <= in_valid_i && !mode_ok;
    end
  end

  assign out_a_o                 = out_a_q;
  assign out_b_o                 = out_b_q;
  assign out_c_o                 = out_c_q;
  assign out_control_dataflow_o  = out_df_q;
  assign out_control_propagate_o = out_prop_q;
  assign out_control_shift_o     = out_sh_q;
  assign out_id_o                = out_id_q;
  assign out_last_o              = out_last_q;
  assign out_valid_o             = out_valid_q;
  assign bad_dataflow_o          = bad_q;

endmodule

// File: tb/tb_pe_param.sv
// Scoreboard bench for pe_param: a both-mode instance and an OS-only instance for the bad-mode case.
module tb_pe_param;
  localparam int IW = 8;
  localparam int OW = 20;
  localparam int SW = 5;
  localparam int DW = 3;
`ifdef PE_SATURATE_EN
  localparam int SatExp = 524287;
`else
  localparam int SatExp = 0;
`endif

  typedef struct packed {
    logic          df;
    logic          prop;
    logic [SW-1:0] sh;
    logic [IW-1:0] a;
    logic [OW-1:0] b;
    logic [OW-1:0] d;
    logic [DW-1:0] id;
    logic          last;
    logic          v;
    logic          rst;
  } stim_t;

  typedef struct packed {
    logic          v;
    logic          bad;
    logic          chk;
    logic [OW-1:0] c;
    logic [OW-1:0] b;
    logic [IW-1:0] a;
    logic [DW-1:0] id;
  } exp_t;

  logic  clk = 1'b0;
  stim_t sm, sx;
  exp_t  q_m[$];
  exp_t  q_x[$];
  exp_t  em, ex_;
  int    n_total = 0;
  int    n_bad   = 0;
  int    beat_no = 0;

  logic [IW-1:0] m_a, x_a;
  logic [OW-1:0] m_b, m_c, x_b, x_c;
  logic          m_df, m_prop, m_last, m_valid, m_badf;
  logic          x_df, x_prop, x_last, x_valid, x_badf;
  logic [SW-1:0] m_sh, x_sh;
  logic [DW-1:0] m_id, x_id;

  always #5 clk = ~clk;

  pe_param #(.DATAFLOW(2)) dut (
    .clk_i(clk), .rst_i(sm.rst), .in_a_i(sm.a), .in_b_i(sm.b), .in_d_i(sm.d),
    .in_control_dataflow_i(sm.df), .in_control_propagate_i(sm.prop),
    .in_control_shift_i(sm.sh), .in_id_i(sm.id), .in_last_i(sm.last), .in_valid_i(sm.v),
    .out_a_o(m_a), .out_b_o(m_b), .out_c_o(m_c), .out_control_dataflow_o(m_df),
    .out_control_propagate_o(m_prop), .out_control_shift_o(m_sh), .out_id_o(m_id),
    .out_last_o(m_last), .out_valid_o(m_valid), .bad_dataflow_o(m_badf)
  );

  pe_param #(.DATAFLOW(0)) dut_os (
    .clk_i(clk), .rst_i(sx.rst), .in_a_i(sx.a), .in_b_i(sx.b), .in_d_i(sx.d),
    .in_control_dataflow_i(sx.df), .in_control_propagate_i(sx.prop),
    .in_control_shift_i(sx.sh), .in_id_i(sx.id), .in_last_i(sx.last), .in_valid_i(sx.v),
    .out_a_o(x_a), .out_b_o(x_b), .out_c_o(x_c), .out_control_dataflow_o(x_df),
    .out_control_propagate_o(x_prop), .out_control_shift_o(x_sh), .out_id_o(x_id),
    .out_last_o(x_last), .out_valid_o(x_valid), .bad_dataflow_o(x_badf)
  );

  function automatic stim_t st(bit df, bit p, int sh, int a, int b, int d, bit v, bit r);
    stim_t s;
    s.df = df;  s.prop = p;  s.sh = SW'(sh);  s.a = IW'(a);  s.b = OW'(b);  s.d = OW'(d);
    s.id = '0;  s.last = 1'b0;  s.v = v;  s.rst = r;
    return s;
  endfunction

  function automatic stim_t os(bit p, int sh, int a, int b, int d);
    return st(1'b0, p, sh, a, b, d, 1'b1, 1'b0);
  endfunction

  function automatic stim_t ws(bit p, int a, int b, int d);
    return st(1'b1, p, 0, a, b, d, 1'b1, 1'b0);
  endfunction

  function automatic exp_t ex(bit v, bit bd, bit chk, int c, int b, int a);
    exp_t e;
    e.v = v;  e.bad = bd;  e.chk = chk;  e.c = OW'(c);  e.b = OW'(b);  e.a = IW'(a);  e.id = '0;
    return e;
  endfunction

  task automatic cmp(input string nm, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Expectations are queued only after the capturing edge, so the monitor sees them in step.
  task automatic drive(input bit alt, input stim_t s, input exp_t e);
    beat_no++;
    s.id = DW'(beat_no);
    s.last = beat_no[0];
    if (e.v) e.id = s.id;
    if (alt) sx = s;
    else     sm = s;
    @(posedge clk);
    #1;
    if (alt) q_x.push_back(e);
    else     q_m.push_back(e);
  endtask

  task automatic check_rec(input string tag, input exp_t e, input logic v, input logic bd,
                           input logic [OW-1:0] c, input logic [OW-1:0] b,
                           input logic [IW-1:0] a, input logic [DW-1:0] id);
    cmp($sformatf("%s.valid", tag), int'(v), int'(e.v));
    cmp($sformatf("%s.bad_dataflow", tag), int'(bd), int'(e.bad));
    if (e.chk) begin
      cmp($sformatf("%s.out_c", tag), int'($signed(c)), int'($signed(e.c)));
      cmp($sformatf("%s.out_b", tag), int'($signed(b)), int'($signed(e.b)));
      cmp($sformatf("%s.out_a", tag), int'($signed(a)), int'($signed(e.a)));
    end
    if (e.v) cmp($sformatf("%s.out_id", tag), int'(id), int'(e.id));
  endtask

  always @(negedge clk) begin
    if (q_m.size() != 0) begin
      em = q_m.pop_front();
      check_rec("main", em, m_valid, m_badf, m_c, m_b, m_a, m_id);
    end
    if (q_x.size() != 0) begin
      ex_ = q_x.pop_front();
      check_rec("os_only", ex_, x_valid, x_badf, x_c, x_b, x_a, x_id);
    end
  end

  initial begin
    sm = st(0, 0, 0, 0, 0, 0, 0, 1);
    sx = st(0, 0, 0, 0, 0, 0, 0, 1);
    // reset state
    drive(0, st(0, 0, 0, 0, 0, 0, 0, 1), ex(0, 0, 1, 0, 0, 0));
    drive(0, st(0, 0, 0, 0, 0, 0, 0, 1), ex(0, 0, 1, 0, 0, 0));
    // OS accumulate into c1, drain on flip
    for (int i = 0; i < 3; i++) drive(0, os(0, 0, 3, 4, 0), ex(1, 0, 1, 0, 4, 3));
    drive(0, os(1, 0, 3, 4, 0), ex(1, 0, 1, 36, 4, 3));
    // rounding: c2 = 12 + 10 = 22, then 26, then -22
    drive(0, os(1, 2, 5, 2, 0),   ex(1, 0, 1, 0, 2, 5));
    drive(0, os(0, 2, 0, 0, 26),  ex(1, 0, 1, 6, 0, 0));
    drive(0, os(1, 2, 0, 0, 0),   ex(1, 0, 1, 0, 0, 0));
    drive(0, os(0, 2, 0, 0, -22), ex(1, 0, 1, 6, 0, 0));
    drive(0, os(1, 2, 0, 0, 0),   ex(1, 0, 1, 0, 0, 0));
    drive(0, os(0, 2, 0, 0, 7),   ex(1, 0, 1, -6, 0, 0));
    // no flip: shift ignored
    drive(0, os(0, 3, 0, 0, 0),   ex(1, 0, 1, 7, 0, 0));
    // saturation: c1 = 2^20
    drive(0, os(0, 0, -128, -8192, 0), ex(1, 0, 1, 0, -8192, -128));
    drive(0, os(1, 0, 0, 0, 0),        ex(1, 0, 1, SatExp, 0, 0));
    // WS: preload c2=5, c1=5, then stream
    drive(0, ws(0, 0, 0, 5),    ex(1, 0, 1, 0, 0, 0));
    drive(0, ws(1, 1, 7, 5),    ex(1, 0, 1, 0, 12, 1));
    drive(0, ws(0, -2, 100, 0), ex(1, 0, 1, 5, 90, -2));
    // reset mid-accumulation (c1 = 5 + 6 + 6)
    drive(0, os(0, 0, 2, 3, 0), ex(1, 0, 1, 0, 3, 2));
    drive(0, os(0, 0, 2, 3, 0), ex(1, 0, 1, 0, 3, 2));
    drive(0, st(0, 0, 0, 2, 3, 0, 1, 1), ex(0, 0, 1, 0, 0, 0));
    drive(0, os(1, 1, 9, 0, 0), ex(1, 0, 1, 0, 0, 9));
    // idle beat holds outputs
    drive(0, st(0, 0, 0, 55, 66, 0, 0, 0), ex(0, 0, 1, 0, 0, 9));
    sm = st(0, 0, 0, 0, 0, 0, 0, 0);

    // OS-only instance: a WS beat is rejected and leaves state alone
    drive(1, st(0, 0, 0, 0, 0, 0, 0, 1), ex(0, 0, 1, 0, 0, 0));
    drive(1, os(0, 0, 2, 5, 0),          ex(1, 0, 1, 0, 5, 2));
    drive(1, st(1, 1, 0, 1, 1, 9, 1, 0), ex(0, 1, 1, 0, 5, 2));
    drive(1, os(1, 0, 0, 0, 0),          ex(1, 0, 1, 10, 0, 0));
    sx = st(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    cmp("queues_drained", q_m.size() + q_x.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_param.md
# pe_param

Parameterised systolic-array processing element: the next-generation successor of the fixed 8/20-bit PE. It supports output-stationary (OS) and weight-stationary (WS) dataflows, selected per beat, with double-buffered accumulator/weight registers, a rounding right-shift on flip, and registered outputs. Instances tile into mesh rows and columns. Row data chains through `in_a`/`out_a`; column data and control chain through the `b`/`c`/`control` ports.

## Interface
- `IN_W`, 8: width of `a` and of the WS weight (signed).
- `OUT_W`, 20: width of `b`, `d`, `out_c` (signed).
- `ACC_W`, 32: width of internal registers `c1`/`c2` (signed); must be ≥ `IN_W+OUT_W`.
- `SHIFT_W`, 5: shift-amount width.
- `ID_W`, 3: id tag width.
- `DATAFLOW`, 2: supported modes; 0 = OS only, 1 = WS only, 2 = both.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_a` in `IN_W`: row operand.
- `in_b` in `OUT_W`: column operand / WS partial sum.
- `in_d` in `OUT_W`: preload value.
- `in_control_dataflow` in 1: 0 = OS, 1 = WS.
- `in_control_propagate` in 1: register-bank select.
- `in_control_shift` in `SHIFT_W`: output shift.
- `in_id` in `ID_W`: tag.
- `in_last` in 1: last-beat tag.
- `in_valid` in 1: beat valid.
- `out_a`, `out_b`, `out_c`, `out_control_*`, `out_id`, `out_last`, `out_valid`: out, same widths as the matching inputs (`out_c` is `OUT_W`). Registered.
- `bad_dataflow` out 1: registered; asserts for an unsupported mode beat.

## Operation
- A beat is accepted when `in_valid`=1. There is no backpressure.
- `ok` = `in_valid` and mode supported. `DATAFLOW`=0 supports only OS; 1 supports only WS; 2 supports both.
- `flip` = (`last_s` != `in_control_propagate`).
- `sh` = `flip` ? `in_control_shift` : 0.
- On `ok`, `last_s` ← `in_control_propagate`.
- OS, propagate=1:
  - `out_c` ← clip(rshift(`c1`, `sh`)); `out_b` ← `in_b`.
  - `c2` ← `c2` + `a`·`b`; `c1` ← sext(`in_d`).
- OS, propagate=0: same as propagate=1 with `c1` and `c2` swapped.
- WS, propagate=1:
  - `out_c` ← clip(`c1`); `out_b` ← clip(`in_b` + `a`·`c2[IN_W-1:0]`).
  - `c1` ← sext(`in_d`).
- WS, propagate=0: same as WS propagate=1 with `c1` and `c2` swapped.
- `rshift(x,s)`:
  - Arithmetic `x>>>s`, plus `r` = (`s`>0) & `x[s-1]` & (|`x[s-2:0]` | `x[s]`).
  - This is round-half-to-even.
- Products are full-width signed; sums are truncated to `ACC_W`.
- `clip` to `OUT_W` is set by the macro (see Configuration).
- `out_a`, `out_control_*`, `out_id`, `out_last` register the inputs.
- On a beat with `in_valid` & !`ok`:
  - `bad_dataflow` ← 1 and `out_valid` ← 0.
  - `c1`, `c2`, `last_s` and the data outputs hold.
- With `in_valid`=0: `out_valid` ← 0; all state and data outputs hold.

## Timing
- Latency is 1 cycle from input beat to registered outputs. Throughput is one beat per cycle.
- `out_valid` ← `ok` every cycle. `bad_dataflow` ← `in_valid` & !`ok` every cycle.
- Reset values: every output is 0; `c1`=`c2`=0; `last_s`=0.
- `rst` dominates a simultaneous valid beat; the beat is dropped.
- Reset mid-accumulation discards the partial sums.
- The first beat after reset with propagate=1 is a flip, so the shift applies.
- Back-to-back flips are legal. Each flip drains one bank and preloads the other.
- Shift ≥ `ACC_W`-1 yields the sign fill, with `r` computed on bit `ACC_W`-1.

## Configuration
- `PE_SATURATE_EN` defined: `clip` saturates to [−2^(`OUT_W`−1), 2^(`OUT_W`−1)−1].
- `PE_SATURATE_EN` undefined: `clip` keeps the low `OUT_W` bits (two's-complement wrap).

## Test plan
- OS accumulate/drain, shift=0:
  - Stimulus: three beats prop=0, `a`=3, `b`=4, `d`=0; then one beat prop=1.
  - Response: the prop=1 beat gives `out_c`=36, `out_b`=4.
- Rounding:
  - Stimulus: bank holds 22, flip with shift=2.
  - Response: `out_c`=6. Repeat with 26 → `out_c`=6 (half-even).
- WS:
  - Stimulus: prop=1 beat with `d`=5; then prop=0 beat with `a`=−2, `b`=100.
  - Response: `out_b`=90, `out_c`=5.
- Saturation:
  - Stimulus: bank holds 2^20, flip with shift=0, `OUT_W`=20.
  - Response: with `PE_SATURATE_EN`, `out_c`=524287; without it, `out_c`=0.
- Bad mode:
  - Stimulus: `DATAFLOW`=0, valid WS beat.
  - Response: `bad_dataflow`=1 and `out_valid`=0 for one cycle. The next OS beat shows `c1`/`c2` unchanged.
- Reset mid-operation:
  - Stimulus: `rst` asserted together with a valid beat after two accumulations.
  - Response: next cycle all outputs are 0. A subsequent flip drains `out_c`=0.
